// File: rtl/ws2812b_pkg.sv
// ws2812b_pkg: shared timing defaults, receiver state encoding and word width
// for the WS2812B line receiver. Timing values are in clk cycles at 12 MHz.
package ws2812b_pkg;

  localparam int PIXEL_W          = 24;
  localparam int MIN_HIGH_DEF     = 2;    // shorter high pulses are glitches
  localparam int BIT_THRESH_DEF   = 7;    // high width >= this decodes as 1
  localparam int MAX_HIGH_DEF     = 14;   // high width reaching this is stuck-high
  localparam int RESET_CYCLES_DEF = 600;  // 50 us low = latch

  typedef enum logic [1:0] {
    WAIT_LATCH = 2'd0,
    IDLE       = 2'd1,
    HIGH       = 2'd2,
    LOW        = 2'd3
  } rx_state_e;

endpackage

// File: rtl/ws2812b_line_sync.sv
// ws2812b_line_sync: two-flop synchronizer for the asynchronous serial line,
// plus single-cycle rise/fall strobes taken against the previous synced value.
//   clk, rst_n : clock, async active-low reset
//   din        : raw line input
//   s_din      : synchronized line
//   rise, fall : edge strobes on s_din (combinational from flops)
module ws2812b_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic s_din,
  output logic rise,
  output logic fall
);

  logic meta_q, sync_q, prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= din;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign s_din = sync_q;
  assign rise  = sync_q & ~prev_q;
  assign fall  = ~sync_q & prev_q;

endmodule

// File: rtl/ws2812b_rx.sv
// ws2812b_rx: WS2812B single-wire receiver. Measures each high pulse to decode
// a bit, assembles 24-bit GRB words, tags them with their index in the frame,
// and flags latch gaps and protocol errors.
//   clk, rst_n  : 12 MHz clock, async active-low reset
//   din         : raw serial line (asynchronous)
//   pixel_data  : last decoded word, first bit received in [23]
//   pixel_index : index of pixel_data within the frame
//   pixel_valid : one-cycle strobe for pixel_data/pixel_index
//   frame_done  : one-cycle strobe on a latch gap following received bits
//   error       : one-cycle strobe on any protocol error
module ws2812b_rx
  import ws2812b_pkg::*;
#(
  parameter int MIN_HIGH     = MIN_HIGH_DEF,
  parameter int BIT_THRESH   = BIT_THRESH_DEF,
  parameter int MAX_HIGH     = MAX_HIGH_DEF,
  parameter int RESET_CYCLES = RESET_CYCLES_DEF,
  parameter int NUM_PIXELS   = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          din,
  output logic [PIXEL_W-1:0]            pixel_data,
  output logic [$clog2(NUM_PIXELS)-1:0] pixel_index,
  output logic                          pixel_valid,
  output logic                          frame_done,
  output logic                          error
);

  localparam int LOW_W  = $clog2(RESET_CYCLES + 1);
  localparam int HIGH_W = $clog2(MAX_HIGH + 1);
  localparam int BIT_W  = $clog2(PIXEL_W);
  localparam int IDX_W  = $clog2(NUM_PIXELS);
  localparam int CNT_W  = $clog2(NUM_PIXELS + 1);  // must hold NUM_PIXELS for saturation

  localparam logic [LOW_W-1:0]  LOW_LAST  = LOW_W'(RESET_CYCLES - 1);
  localparam logic [HIGH_W-1:0] H_MIN     = HIGH_W'(MIN_HIGH);
  localparam logic [HIGH_W-1:0] H_THRESH  = HIGH_W'(BIT_THRESH);
  localparam logic [HIGH_W-1:0] H_MAX     = HIGH_W'(MAX_HIGH);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(PIXEL_W - 1);
  localparam logic [CNT_W-1:0]  PIX_LIMIT = CNT_W'(NUM_PIXELS);

  logic s_din, rise, fall;

  ws2812b_line_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (din),
    .s_din (s_din),
    .rise  (rise),
    .fall  (fall)
  );

  rx_state_e          state_q;
  logic [LOW_W-1:0]   low_cnt_q;
  logic [HIGH_W-1:0]  high_cnt_q;
  logic [BIT_W-1:0]   bit_cnt_q;
  logic [PIXEL_W-1:0] shift_q;
  logic [CNT_W-1:0]   pix_cnt_q;
  logic               pix_done_q;  // full word sits in shift_q this cycle
  logic               ovr_q;       // overrun already reported this frame

  // The fall cycle counts as one more increment, so h_next at the fall
  // strobe equals the number of synced high cycles.
  logic [HIGH_W-1:0] h_next;
  assign h_next = high_cnt_q + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= WAIT_LATCH;
      low_cnt_q   <= '0;
      high_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      pix_cnt_q   <= '0;
      pix_done_q  <= 1'b0;
      ovr_q       <= 1'b0;
      pixel_data  <= '0;
      pixel_index <= '0;
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      error       <= 1'b0;
    end else begin
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      error       <= 1'b0;

      // Publish a completed word one cycle after its last bit shifted in.
      if (pix_done_q) begin
        pix_done_q <= 1'b0;
        if (pix_cnt_q < PIX_LIMIT) begin
          pixel_data  <= shift_q;
          pixel_index <= pix_cnt_q[IDX_W-1:0];
          pixel_valid <= 1'b1;
          pix_cnt_q   <= pix_cnt_q + 1'b1;
        end else if (!ovr_q) begin
          error <= 1'b1;
          ovr_q <= 1'b1;
        end
      end

      case (state_q)
        WAIT_LATCH: begin
          if (s_din) begin
            low_cnt_q <= '0;
          end else if (low_cnt_q == LOW_LAST) begin
            low_cnt_q <= '0;
            state_q   <= IDLE;
          end else begin
            low_cnt_q <= low_cnt_q + 1'b1;
          end
        end

        IDLE: begin
          if (rise) begin
            high_cnt_q <= '0;
            state_q    <= HIGH;
          end
        end

        HIGH: begin
          high_cnt_q <= h_next;
          if (h_next >= H_MAX || (fall && h_next < H_MIN)) begin
            // stuck-high or glitch: drop the frame and resync on a latch gap
            error     <= 1'b1;
            bit_cnt_q <= '0;
            pix_cnt_q <= '0;
            ovr_q     <= 1'b0;
            low_cnt_q <= '0;
            state_q   <= WAIT_LATCH;
          end else if (fall) begin
            shift_q   <= {shift_q[PIXEL_W-2:0], (h_next >= H_THRESH)};
            low_cnt_q <= '0;
            state_q   <= LOW;
            if (bit_cnt_q == BIT_LAST) begin
              bit_cnt_q  <= '0;
              pix_done_q <= 1'b1;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end

        LOW: begin
          // latch wins over a rise arriving in the same cycle
          if (low_cnt_q == LOW_LAST) begin
            frame_done <= 1'b1;
            error      <= (bit_cnt_q != '0);
            bit_cnt_q  <= '0;
            pix_cnt_q  <= '0;
            ovr_q      <= 1'b0;
            low_cnt_q  <= '0;
            state_q    <= IDLE;
          end else if (rise) begin
            high_cnt_q <= '0;
            state_q    <= HIGH;
          end else begin
            low_cnt_q <= low_cnt_q + 1'b1;
          end
        end

        default: state_q <= WAIT_LATCH;
      endcase
    end
  end

endmodule
